// File: rtl/demux_subtrator_pkg.sv
// Shared types and default sizes for the demux_subtrator datapath.
package demux_subtrator_pkg;

    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

endpackage

// File: rtl/subtrator_borrow.sv
// Combinational (W+1)-bit minus W-bit subtractor exposing borrow and
// overflow (difference that does not fit back into W bits).
module subtrator_borrow #(
    parameter int W = 4
) (
    input  logic [W:0]   total_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] dif_o,
    output logic         borrow_o,
    output logic         overflow_o
);

    // One extra bit beyond the sum width keeps the borrow out of the MSB.
    logic [W+1:0] dif_full;

    assign dif_full   = {1'b0, total_i} - {2'b00, a_i};
    assign dif_o      = dif_full[W-1:0];
    assign borrow_o   = dif_full[W+1];
    assign overflow_o = ~dif_full[W+1] & dif_full[W];

endmodule

// File: rtl/demux_subtrator.sv
// Recovers operand B = total - A and routes it to saidaB/saidaC by select.
// Define DEMUX_SUBTRATOR_SAT_EN to saturate overflowing differences and flag erro.
module demux_subtrator
    import demux_subtrator_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entrada_valida,
    output logic             pronto,
    input  logic [W:0]       resultado_total,
    input  logic [W-1:0]     entradaA,
    input  logic             sel_demux,
    input  logic             aceita,
    output logic [W-1:0]     saidaB,
    output logic [W-1:0]     saidaC,
    output logic             valida_B,
    output logic             valida_C,
    output logic             erro,
    output logic [CNT_W-1:0] contador
);

    estado_t          estado_q;
    logic [W:0]       total_q;
    logic [W-1:0]     a_q;
    logic             sel_q;
    logic             pronto_q;
    logic [W-1:0]     saidaB_q, saidaC_q;
    logic             valida_B_q, valida_C_q, erro_q;
    logic [CNT_W-1:0] contador_q;

    logic [W-1:0]     dif;
    logic             borrow, overflow;
    logic [W-1:0]     res_d;
    logic             erro_d;

    subtrator_borrow #(.W(W)) u_sub (
        .total_i    (total_q),
        .a_i        (a_q),
        .dif_o      (dif),
        .borrow_o   (borrow),
        .overflow_o (overflow)
    );

    always_comb begin
        res_d  = dif;
        erro_d = 1'b0;
        if (borrow) begin
            res_d  = '0;
            erro_d = 1'b1;
        end
`ifdef DEMUX_SUBTRATOR_SAT_EN
        else if (overflow) begin
            res_d  = '1;
            erro_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            total_q    <= '0;
            a_q        <= '0;
            sel_q      <= 1'b0;
            pronto_q   <= 1'b1;
            saidaB_q   <= '0;
            saidaC_q   <= '0;
            valida_B_q <= 1'b0;
            valida_C_q <= 1'b0;
            erro_q     <= 1'b0;
            contador_q <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (entrada_valida) begin
                        total_q  <= resultado_total;
                        a_q      <= entradaA;
                        sel_q    <= sel_demux;
                        pronto_q <= 1'b0;
                        estado_q <= CALCULA;
                    end
                end
                CALCULA: begin
                    // Only the selected output is reloaded; the other keeps its last value.
                    if (sel_q) begin
                        saidaC_q   <= res_d;
                        valida_C_q <= 1'b1;
                    end else begin
                        saidaB_q   <= res_d;
                        valida_B_q <= 1'b1;
                    end
                    erro_q   <= erro_d;
                    estado_q <= ENTREGA;
                end
                ENTREGA: begin
                    if (aceita) begin
                        valida_B_q <= 1'b0;
                        valida_C_q <= 1'b0;
                        erro_q     <= 1'b0;
                        contador_q <= contador_q + 1'b1;
                        pronto_q   <= 1'b1;
                        estado_q   <= OCIOSO;
                    end
                end
                default: begin
                    pronto_q <= 1'b1;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign pronto   = pronto_q;
    assign saidaB   = saidaB_q;
    assign saidaC   = saidaC_q;
    assign valida_B = valida_B_q;
    assign valida_C = valida_C_q;
    assign erro     = erro_q;
    assign contador = contador_q;

endmodule

// File: tb/tb_demux_subtrator.sv
// Directed bench for demux_subtrator: arithmetic model plus per-cycle output compare.
module tb_demux_subtrator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entrada_valida = 1'b0;
    logic       pronto;
    logic [4:0] resultado_total = '0;
    logic [3:0] entradaA = '0;
    logic       sel_demux = 1'b0;
    logic       aceita = 1'b0;
    logic [3:0] saidaB, saidaC;
    logic       valida_B, valida_C, erro;
    logic [7:0] contador;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected output state, updated by the driver at the points the outputs must change.
    int exp_B = 0, exp_C = 0, exp_vB = 0, exp_vC = 0, exp_err = 0, exp_cnt = 0, exp_pronto = 1;

    demux_subtrator #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .entrada_valida(entrada_valida), .pronto(pronto),
        .resultado_total(resultado_total), .entradaA(entradaA), .sel_demux(sel_demux),
        .aceita(aceita), .saidaB(saidaB), .saidaC(saidaC), .valida_B(valida_B),
        .valida_C(valida_C), .erro(erro), .contador(contador)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Recovered operand from plain integer arithmetic.
    task automatic model(input int t, input int a, output int r, output int e);
        int d;
        d = t - a;
        if (d < 0) begin
            r = 0; e = 1;
        end else if (d > 15) begin
`ifdef DEMUX_SUBTRATOR_SAT_EN
            r = 15; e = 1;
`else
            r = d % 16; e = 0;
`endif
        end else begin
            r = d; e = 0;
        end
    endtask

    always @(negedge clk) begin
        chk("pronto",   int'(pronto),   exp_pronto);
        chk("saidaB",   int'(saidaB),   exp_B);
        chk("saidaC",   int'(saidaC),   exp_C);
        chk("valida_B", int'(valida_B), exp_vB);
        chk("valida_C", int'(valida_C), exp_vC);
        chk("erro",     int'(erro),     exp_err);
        chk("contador", int'(contador), exp_cnt);
    end

    task automatic set_reset_exp();
        exp_B = 0; exp_C = 0; exp_vB = 0; exp_vC = 0; exp_err = 0; exp_cnt = 0; exp_pronto = 1;
    endtask

    // One full transaction; hold = extra ENTREGA cycles with aceita low,
    // noise = drive entrada_valida/garbage during those cycles.
    task automatic txn(input int t, input int a, input int s, input int hold, input bit noise);
        int r, e;
        @(negedge clk);
        entrada_valida = 1'b1; resultado_total = 5'(t); entradaA = 4'(a); sel_demux = s[0];
        @(posedge clk); #1;
        entrada_valida = 1'b0;
        exp_pronto = 0;
        @(posedge clk); #1;
        model(t, a, r, e);
        if (s != 0) begin exp_C = r; exp_vC = 1; end
        else        begin exp_B = r; exp_vB = 1; end
        exp_err = e;
        repeat (hold) begin
            @(negedge clk);
            entrada_valida = noise;
            resultado_total = 5'($urandom);
            entradaA = 4'($urandom);
            sel_demux = ~sel_demux;
        end
        @(negedge clk);
        entrada_valida = 1'b0;
        aceita = 1'b1;
        @(posedge clk); #1;
        aceita = 1'b0;
        exp_vB = 0; exp_vC = 0; exp_err = 0; exp_pronto = 1;
        exp_cnt = (exp_cnt + 1) % 256;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_pronto", int'(pronto), 1);
        chk("reset_contador", int'(contador), 0);

        // B path: 8 - 3 = 5; valid only after the second edge.
        @(negedge clk);
        entrada_valida = 1'b1; resultado_total = 5'b01000; entradaA = 4'b0011; sel_demux = 1'b0;
        @(posedge clk); #1;
        entrada_valida = 1'b0; exp_pronto = 0;
        chk("lat_vB_early", int'(valida_B), 0);
        @(posedge clk); #1;
        exp_B = 5; exp_vB = 1;
        chk("B_lit", int'(saidaB), 4'b0101);
        chk("B_vld_lit", int'(valida_B), 1);
        chk("B_err_lit", int'(erro), 0);
        @(negedge clk); aceita = 1'b1;
        @(posedge clk); #1;
        aceita = 1'b0;
        exp_vB = 0; exp_pronto = 1; exp_cnt = 1;
        chk("B_cnt_lit", int'(contador), 1);

        // C path: 9 - 7 = 2; saidaB keeps 5.
        txn(5'b01001, 4'b0111, 1, 0, 1'b0);
        chk("C_lit", int'(saidaC), 4'b0010);
        chk("C_keepB_lit", int'(saidaB), 4'b0101);

        // Borrow: 0 - 1.
        txn(0, 1, 0, 0, 1'b0);
        chk("borrow_B_lit", int'(saidaB), 0);
        chk("borrow_cnt_lit", int'(contador), 3);

        // Overflow: 31 - 15 = 16.
        txn(31, 15, 1, 1, 1'b0);
`ifdef DEMUX_SUBTRATOR_SAT_EN
        chk("ovf_C_lit", int'(saidaC), 4'b1111);
`else
        chk("ovf_C_lit", int'(saidaC), 4'b0000);
`endif

        // Zero case and a few mixed vectors.
        txn(0, 0, 0, 0, 1'b0);
        txn(20, 6, 1, 2, 1'b0);
        txn(15, 15, 0, 0, 1'b0);
        txn(17, 0, 1, 0, 1'b0);

        // Backpressure with noisy upstream for 5 cycles.
        txn(10, 4, 0, 5, 1'b1);
        chk("bp_B_lit", int'(saidaB), 6);
        chk("bp_pronto_lit", int'(pronto), 1);

        // Asynchronous reset during CALCULA.
        @(negedge clk);
        entrada_valida = 1'b1; resultado_total = 5'd12; entradaA = 4'd2; sel_demux = 1'b1;
        @(posedge clk); #1;
        entrada_valida = 1'b0; exp_pronto = 0;
        #2 rst_n = 1'b0;
        set_reset_exp();
        #1;
        chk("rst_saidaB", int'(saidaB), 0);
        chk("rst_saidaC", int'(saidaC), 0);
        chk("rst_contador", int'(contador), 0);
        chk("rst_pronto", int'(pronto), 1);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("post_rst_vC", int'(valida_C), 0);

        // Counter wrap after 256 accepted transactions.
        for (int i = 0; i < 256; i++)
            txn(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 0, 1'b0);
        chk("wrap_lit", int'(contador), 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
